// File: rtl/robin_pkg.sv
// Shared command bytes and loader state encoding for the host-side program loader.
package robin_pkg;

   localparam logic [7:0] CMD_LOAD = 8'h4C;
   localparam logic [7:0] CMD_READ = 8'h52;
   localparam logic [7:0] CMD_GO   = 8'h47;
   localparam logic [7:0] CMD_STOP = 8'h58;
   localparam logic [7:0] RSP_OK   = 8'h4B;
   localparam logic [7:0] RSP_HALT = 8'h48;
   localparam logic [7:0] RSP_ERR  = 8'h3F;

   typedef logic [2:0] loader_state_t;

   localparam loader_state_t ST_IDLE  = 3'd0;
   localparam loader_state_t ST_HDR   = 3'd1;
   localparam loader_state_t ST_LOAD  = 3'd2;
   localparam loader_state_t ST_RADDR = 3'd3;
   localparam loader_state_t ST_RSEND = 3'd4;
   localparam loader_state_t ST_GO    = 3'd5;
   localparam loader_state_t ST_RUN   = 3'd6;
   localparam loader_state_t ST_ACK   = 3'd7;

   // Go carries only an address; load and read also carry a 16-bit length.
   function automatic logic [2:0] hdr_bytes(input logic [7:0] cmd);
      return (cmd == CMD_GO) ? 3'd2 : 3'd4;
   endfunction

endpackage

// File: rtl/loader_hdr.sv
// Header byte collector: shifts incoming bytes into a word and flags the last one.
module loader_hdr (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic [2:0]  need,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic [31:0] word_next,
   output logic        last
);

   logic [23:0] word_q;
   logic [2:0]  cnt_q;

   // word_next includes the byte on the bus so the caller can act in the same cycle.
   assign word_next = {word_q, in_data};
   assign last      = in_valid && (cnt_q == need - 3'd1);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         word_q <= 24'h0;
         cnt_q  <= 3'd0;
      end else if (in_valid) begin
         word_q <= word_next[23:0];
         cnt_q  <= cnt_q + 3'd1;
      end
   end

endmodule

// File: rtl/prog_loader.sv
// UART-driven program loader/monitor: loads RAM, dumps RAM, and runs the cpu until halted.
module prog_loader
   import robin_pkg::*;
#(
   parameter int unsigned addr_width = 9,
   parameter int unsigned rd_lat     = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic [addr_width-1:0] mem_raddr,
   input  logic [7:0]            mem_rdata,
   output logic [addr_width-1:0] mem_waddr,
   output logic [7:0]            mem_wdata,
   output logic                  mem_write,
   output logic                  cpu_reset,
   output logic                  cpu_halt,
   input  logic                  cpu_halted,
   output logic [addr_width-1:0] start_address,
   output logic                  busy
);

   typedef logic [addr_width-1:0] addr_t;

   localparam logic [7:0] WAIT_LAST = 8'(rd_lat - 1);

   loader_state_t state_q, state_d;
   addr_t         addr_q, addr_d;
   addr_t         start_q, start_d;
   logic [15:0]   len_q, len_d;
   logic [7:0]    cmd_q, cmd_d;
   logic [7:0]    rsp_q, rsp_d;
   logic [7:0]    wait_q, wait_d;
   addr_t         mem_waddr_q;
   logic [7:0]    mem_wdata_q;
   logic          mem_write_q;
   logic          cpu_halt_q;

   logic [31:0]   hdr_word;
   logic          hdr_last;
   logic          unused_hdr;

   loader_hdr u_hdr (
      .clk       (clk),
      .reset     (reset),
      .clear     (state_q != ST_HDR),
      .need      (hdr_bytes(cmd_q)),
      .in_valid  (rx_valid && (state_q == ST_HDR)),
      .in_data   (rx_data),
      .word_next (hdr_word),
      .last      (hdr_last)
   );

   assign unused_hdr = ^hdr_word[31:16+addr_width];

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      start_d  = start_q;
      len_d    = len_q;
      cmd_d    = cmd_q;
      rsp_d    = rsp_q;
      wait_d   = wait_q;
      rx_ready = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      unique case (state_q)
         ST_IDLE: begin
            rx_ready = 1'b1;
            if (rx_valid) begin
               cmd_d = rx_data;
               if (rx_data == CMD_LOAD || rx_data == CMD_READ || rx_data == CMD_GO) begin
                  state_d = ST_HDR;
               end else begin
                  rsp_d   = RSP_ERR;
                  state_d = ST_ACK;
               end
            end
         end
         ST_HDR: begin
            rx_ready = 1'b1;
            if (hdr_last) begin
               if (cmd_q == CMD_GO) begin
                  addr_d  = hdr_word[addr_width-1:0];
                  state_d = ST_GO;
               end else begin
                  addr_d = hdr_word[16 +: addr_width];
                  len_d  = hdr_word[15:0];
                  rsp_d  = RSP_OK;
                  wait_d = 8'd0;
                  if (hdr_word[15:0] == 16'd0) begin
                     state_d = ST_ACK;
                  end else if (cmd_q == CMD_LOAD) begin
                     state_d = ST_LOAD;
                  end else begin
                     state_d = ST_RADDR;
                  end
               end
            end
         end
         ST_LOAD: begin
            rx_ready = 1'b1;
            if (rx_valid) begin
               addr_d = addr_q + addr_t'(1);
               len_d  = len_q - 16'd1;
               if (len_q == 16'd1) state_d = ST_ACK;
            end
         end
         ST_RADDR: begin
            if (wait_q == WAIT_LAST) state_d = ST_RSEND;
            else                     wait_d  = wait_q + 8'd1;
         end
         ST_RSEND: begin
            // mem_raddr is held on addr_q, so mem_rdata stays stable under back-pressure.
            tx_valid = 1'b1;
            tx_data  = mem_rdata;
            if (tx_ready) begin
               addr_d  = addr_q + addr_t'(1);
               len_d   = len_q - 16'd1;
               wait_d  = 8'd0;
               state_d = (len_q == 16'd1) ? ST_ACK : ST_RADDR;
            end
         end
         ST_GO: begin
            start_d = addr_q;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            rx_ready = 1'b1;
            if (cpu_halted) begin
               rsp_d   = RSP_HALT;
               state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            tx_valid = 1'b1;
            tx_data  = rsp_q;
            if (tx_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (reset) begin
         rx_ready = 1'b0;
         tx_valid = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         start_q     <= '0;
         len_q       <= 16'd0;
         cmd_q       <= 8'h00;
         rsp_q       <= 8'h00;
         wait_q      <= 8'd0;
         mem_waddr_q <= '0;
         mem_wdata_q <= 8'h00;
         mem_write_q <= 1'b0;
         cpu_halt_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         start_q     <= start_d;
         len_q       <= len_d;
         cmd_q       <= cmd_d;
         rsp_q       <= rsp_d;
         wait_q      <= wait_d;
         mem_write_q <= (state_q == ST_LOAD) && rx_valid;
         if ((state_q == ST_LOAD) && rx_valid) begin
            mem_waddr_q <= addr_q;
            mem_wdata_q <= rx_data;
         end
         // Pulsed even if cpu_halted arrives together with the stop byte.
         cpu_halt_q  <= (state_q == ST_RUN) && rx_valid && (rx_data == CMD_STOP);
      end
   end

   assign mem_raddr     = addr_q;
   assign mem_waddr     = mem_waddr_q;
   assign mem_wdata     = mem_wdata_q;
   assign mem_write     = mem_write_q;
   assign cpu_reset     = (state_q != ST_RUN);
   assign cpu_halt      = cpu_halt_q;
   assign start_address = start_q;
   assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader with RAM and cpu models and a byte-level reference.
module tb_prog_loader;
   import robin_pkg::*;

   localparam int AW = 9;
   localparam int MEM = 1 << AW;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [7:0]    rx_data = 8'h00;
   logic          rx_valid = 1'b0;
   logic          rx_ready;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready = 1'b1;
   logic [AW-1:0] mem_raddr;
   logic [7:0]    mem_rdata;
   logic [AW-1:0] mem_waddr;
   logic [7:0]    mem_wdata;
   logic          mem_write;
   logic          cpu_reset;
   logic          cpu_halt;
   logic          cpu_halted;
   logic [AW-1:0] start_address;
   logic          busy;

   int checks = 0;
   int errors = 0;
   int tx_mode = 0;
   int halt_pulses = 0;
   bit saw_run = 0;

   logic [7:0]  ram   [MEM];
   logic [7:0]  model [MEM];
   logic [7:0]  rd1;
   logic [7:0]  exp_tx [$];
   logic [16:0] exp_wr [$];
   logic [7:0]  pay [$];
   logic [7:0]  run_cnt;
   logic        halt_req;

   prog_loader #(.addr_width(AW), .rd_lat(2)) dut (
      .clk           (clk),
      .reset         (reset),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_ready      (rx_ready),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .mem_raddr     (mem_raddr),
      .mem_rdata     (mem_rdata),
      .mem_waddr     (mem_waddr),
      .mem_wdata     (mem_wdata),
      .mem_write     (mem_write),
      .cpu_reset     (cpu_reset),
      .cpu_halt      (cpu_halt),
      .cpu_halted    (cpu_halted),
      .start_address (start_address),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   // RAM with two-cycle read latency; the loader owns the write port while cpu_reset is high.
   always @(posedge clk) begin
      if (mem_write && cpu_reset) ram[mem_waddr] <= mem_wdata;
      rd1       <= ram[mem_raddr];
      mem_rdata <= rd1;
   end

   // cpu model: a program starting with 0xFF halts by itself, anything else loops until cpu_halt.
   always @(posedge clk) begin
      if (cpu_reset) begin
         cpu_halted <= 1'b0;
         run_cnt    <= 8'd0;
         halt_req   <= 1'b0;
      end else begin
         if (run_cnt != 8'hFF) run_cnt <= run_cnt + 8'd1;
         if (cpu_halt) halt_req <= 1'b1;
         if (halt_req || (ram[start_address] == 8'hFF && run_cnt >= 8'd4)) cpu_halted <= 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (tx_valid && tx_ready) begin
         if (exp_tx.size() == 0) chk("tx_extra", 32'(tx_data), 32'h100);
         else                    chk("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
      end
      if (mem_write) begin
         chk("wr_owner", 32'(cpu_reset), 32'd1);
         if (exp_wr.size() == 0) begin
            chk("wr_extra", 32'(mem_waddr), 32'h10000);
         end else begin
            logic [16:0] w;
            w = exp_wr.pop_front();
            chk("wr_addr", 32'(mem_waddr), 32'(w[16:8]));
            chk("wr_data", 32'(mem_wdata), 32'(w[7:0]));
         end
      end
      if (cpu_halt) halt_pulses++;
      if (!cpu_reset) saw_run = 1'b1;
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (tx_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ~tx_ready;
            default: tx_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   task automatic send_byte(input logic [7:0] b);
      bit ok;
      ok = 1'b0;
      rx_data  = b;
      rx_valid = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (rx_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      chk("rx_accept", 32'(ok), 32'd1);
      repeat ($urandom_range(0, 2)) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_idle(input string tag);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (exp_tx.size() == 0 && exp_wr.size() == 0 && !busy) begin
            ok = 1'b1;
            break;
         end
      end
      chk(tag, 32'(ok), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic send_hdr(input logic [7:0] cmd, input int unsigned addr, input logic [6:0] junk,
                           input logic [15:0] len);
      logic [15:0] a16;
      a16 = {junk, 9'(addr)};
      send_byte(cmd);
      send_byte(a16[15:8]);
      send_byte(a16[7:0]);
      send_byte(len[15:8]);
      send_byte(len[7:0]);
   endtask

   task automatic do_load(input int unsigned addr, input logic [6:0] junk);
      int unsigned a;
      for (int i = 0; i < pay.size(); i++) begin
         a = (addr + i) % MEM;
         exp_wr.push_back({9'(a), pay[i]});
         model[a] = pay[i];
      end
      exp_tx.push_back(RSP_OK);
      send_hdr(CMD_LOAD, addr, junk, 16'(pay.size()));
      for (int i = 0; i < pay.size(); i++) send_byte(pay[i]);
      wait_idle("load_done");
   endtask

   task automatic do_read(input int unsigned addr, input int unsigned len, input logic [6:0] junk);
      for (int i = 0; i < len; i++) exp_tx.push_back(model[(addr + i) % MEM]);
      exp_tx.push_back(RSP_OK);
      send_hdr(CMD_READ, addr, junk, 16'(len));
      wait_idle("read_done");
   endtask

   task automatic send_go(input int unsigned addr);
      logic [15:0] a16;
      a16 = 16'(addr);
      send_byte(CMD_GO);
      send_byte(a16[15:8]);
      send_byte(a16[7:0]);
   endtask

   task automatic wait_run(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!cpu_reset) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      bit ok;
      logic [7:0] b;
      for (int i = 0; i < MEM; i++) begin
         ram[i]   = 8'h00;
         model[i] = 8'h00;
      end
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_mem_write", 32'(mem_write), 32'd0);
      chk("rst_mem_waddr", 32'(mem_waddr), 32'd0);
      chk("rst_mem_raddr", 32'(mem_raddr), 32'd0);
      chk("rst_cpu_halt", 32'(cpu_halt), 32'd0);
      chk("rst_start", 32'(start_address), 32'd0);
      @(posedge clk);
      #1;

      pay = '{8'hAA, 8'hBB, 8'hCC};
      do_load(32'h010, 7'd0);
      tx_mode = 1;
      do_read(32'h010, 3, 7'd0);
      tx_mode = 0;

      pay = '{8'h5A, 8'hA5};
      do_load(32'h1FF, 7'd0);
      do_read(32'h1FF, 2, 7'd0);

      pay = '{8'hFF, 8'hFF};
      do_load(32'h040, 7'd0);
      saw_run = 1'b0;
      exp_tx.push_back(RSP_HALT);
      send_go(32'h040);
      wait_run(ok);
      chk("go_run", 32'(ok), 32'd1);
      chk("go_start", 32'(start_address), 32'h040);
      wait_idle("go_done");
      chk("go_saw_run", 32'(saw_run), 32'd1);
      chk("go_cpu_reset", 32'(cpu_reset), 32'd1);

      pay = '{8'h00};
      do_load(32'h080, 7'd0);
      halt_pulses = 0;
      exp_tx.push_back(RSP_HALT);
      send_go(32'h080);
      wait_run(ok);
      chk("loop_run", 32'(ok), 32'd1);
      repeat (20) @(posedge clk);
      #1;
      chk("loop_running", 32'(cpu_reset), 32'd0);
      send_byte(8'h59);
      repeat (5) @(posedge clk);
      #1;
      chk("loop_ignore", 32'(cpu_reset), 32'd0);
      chk("loop_no_halt", 32'(halt_pulses), 32'd0);
      send_byte(CMD_STOP);
      wait_idle("stop_done");
      chk("halt_pulses", 32'(halt_pulses), 32'd1);
      chk("stop_cpu_reset", 32'(cpu_reset), 32'd1);

      exp_tx.push_back(RSP_ERR);
      send_byte(8'h00);
      wait_idle("err_done");

      // Reset lands while the first of three load bytes is being written.
      exp_wr.push_back({9'h020, 8'h11});
      model[9'h020] = 8'h11;
      send_hdr(CMD_LOAD, 32'h020, 7'd0, 16'd3);
      send_byte(8'h11);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("abort_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_mem_write", 32'(mem_write), 32'd0);
      chk("abort_wr_seen", 32'(exp_wr.size()), 32'd0);
      @(posedge clk);
      #1;
      tx_mode = 2;
      do_read(32'h020, 3, 7'd0);

      for (int it = 0; it < 8; it++) begin
         int unsigned addr;
         int unsigned len;
         addr = $urandom_range(0, MEM - 1);
         len  = $urandom_range(0, 6);
         pay.delete();
         for (int i = 0; i < len; i++) pay.push_back(8'($urandom_range(0, 255)));
         tx_mode = $urandom_range(0, 2);
         do_load(addr, 7'($urandom_range(0, 127)));
         do_read(addr, len, 7'($urandom_range(0, 127)));
      end

      tx_mode = 2;
      b = 8'($urandom_range(0, 255));
      if (b == CMD_LOAD || b == CMD_READ || b == CMD_GO) b = 8'h21;
      exp_tx.push_back(RSP_ERR);
      send_byte(b);
      wait_idle("rand_err_done");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Host-side loader/monitor that sits directly upstream of the cpu core and shares its byte-wide RAM port.
- Consumes a byte stream from the UART receiver and writes program images into RAM.
- Starts the cpu at a given address, waits for it to report halted, and returns acknowledgements and memory dumps through the UART transmitter.
- Owns the RAM port whenever cpu_reset is high; an external mux selects the cpu port otherwise.

Parameters:
- addr_width, 9, RAM address width; must match the cpu's addr_width.
- rd_lat, 2, cycles from a mem_raddr change to valid mem_rdata.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts rx_data this cycle
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts tx_data
- mem_raddr  out  addr_width  RAM read address
- mem_rdata  in  8  RAM read data
- mem_waddr  out  addr_width  RAM write address
- mem_wdata  out  8  RAM write data
- mem_write  out  1  one-cycle write strobe
- cpu_reset  out  1  cpu reset and RAM-port select (1 = loader owns RAM)
- cpu_halt  out  1  one-cycle halt request to cpu
- cpu_halted  in  1  cpu has stored ip and stopped
- start_address  out  addr_width  cpu start address
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - cpu_reset=1; all other outputs 0, including start_address.
  - state=IDLE.
- Handshakes:
  - A byte transfers on rx_valid&rx_ready, or on tx_valid&tx_ready.
  - tx_data is stable while tx_valid=1 and tx_ready=0.
  - rx_ready=1 only in IDLE, HDR, LOAD and RUN.
- Commands (first byte in IDLE):
  - 'L' (0x4C): header addr_hi, addr_lo, len_hi, len_lo; then len data bytes.
  - 'R' (0x52): header addr_hi, addr_lo, len_hi, len_lo; loader transmits len bytes.
  - 'G' (0x47): header addr_hi, addr_lo; run the cpu.
  - Any other byte: transmit '?' (0x3F), return to IDLE.
- Addresses and lengths:
  - Addresses use the low addr_width bits of {hi,lo}.
  - Length is 16 bits; len=0 skips data and goes straight to the ACK.
  - Address increments wrap modulo 2^addr_width.
- States:
  - IDLE -> HDR: collect 4 header bytes (2 for G).
  - HDR -> LOAD | RADDR | GO.
  - LOAD: each accepted byte gives mem_waddr=addr, mem_wdata=byte, mem_write=1 for exactly one cycle; then addr++, len--. At len=0 -> ACK.
  - RADDR: drive mem_raddr, wait rd_lat cycles -> RSEND.
  - RSEND: present mem_rdata as tx_data until accepted; then addr++, len--. len=0 -> ACK, else -> RADDR.
  - GO: load start_address; cpu_reset=1 for this cycle; next cycle cpu_reset=0 -> RUN.
  - RUN: cpu_reset=0. An rx byte 'X' (0x58) gives cpu_halt=1 for one cycle; other bytes are consumed and ignored. cpu_halted=1 -> cpu_reset=1 -> ACK.
  - ACK: transmit 'K' (0x4B) for L and R, 'H' (0x48) for G -> IDLE.
- Boundary conditions:
  - cpu_halted arriving in the same cycle as an 'X' byte: the halted exit wins; cpu_halt is still pulsed (harmless).
  - Loader never drives mem_write while cpu_reset=0.
  - reset mid-command: abort immediately with no further writes; any partial load remains in RAM; cpu_reset returns to 1.
  - Back-pressure (tx_ready=0) stalls RSEND/ACK indefinitely with no byte lost or duplicated.

Decomposition:
- Shared package (robin_pkg): command byte constants (CMD_LOAD, CMD_READ, CMD_GO, CMD_STOP, RSP_OK, RSP_HALT, RSP_ERR) and the loader state enum.
- One sub-module, loader_hdr: a byte collector that shifts N header bytes into a 32-bit register and flags done.

Test Plan:
- 'L',0x00,0x10,0x00,0x03,0xAA,0xBB,0xCC -> exactly three mem_write pulses at 0x010/0x011/0x012 with data AA/BB/CC; tx 0x4B.
- After that load, 'R',0x00,0x10,0x00,0x03 with tx_ready toggling every cycle -> tx sequence AA,BB,CC,4B with no repeats.
- 'L' at addr 0x1FF, len 2 (addr_width=9) -> writes at 0x1FF then 0x000 (wrap); tx 0x4B.
- Load 0xFF,0xFF at 0x040, then 'G',0x00,0x40 -> start_address=0x040, cpu_reset drops for the run; after the model cpu asserts cpu_halted, cpu_reset=1 and tx 0x48.
- 'G' with a looping program, then send 'X' -> single-cycle cpu_halt; model halts; tx 0x48. Byte 0x00 in IDLE -> tx 0x3F.
- Assert reset in the middle of LOAD after 1 of 3 bytes -> no further mem_write, cpu_reset=1, busy=0; the next 'R' command works normally.
